// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses of the bit-serial adder.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;

   modport master (output start, a, b, cin, input busy, done, s, c);
   modport slave  (input start, a, b, cin, output busy, done, s, c);
endinterface

// File: rtl/serial_adder_fa.sv
// Combinational full adder built from two half adders; the carry flop lives in the caller.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;
   logic g0;
   logic g1;

   ha u_ha0 (.a(a), .b(b),  .s(p), .co(g0));
   ha u_ha1 (.a(p), .b(ci), .s(s), .co(g1));

   assign co = g0 | g1;

endmodule

// File: rtl/serial_adder_ha.sv
// Gate-level half adder: the basic cell the bit-serial datapath is built from.
module ha (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);

   assign s  = a ^ b;
   assign co = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per clock, LSB first, result {c,s} = a + b + cin after WIDTH cycles.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;
   localparam int   CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic             state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_shifted;

   fa u_fa (.a(a_sr_q[0]), .b(b_sr_q[0]), .ci(carry_q), .s(fa_s), .co(fa_co));

   assign sum_shifted = {fa_s, sum_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         s_q      <= '0;
         c_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         s_q      <= s_d;
         c_q      <= c_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      c_d      = c_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         default: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_shifted;
            carry_d  = fa_co;
            cnt_d    = cnt_q + CNT_W'(1);
            // The last bit goes straight to s so the result lands on the same edge as the final carry.
            if (cnt_q == CNT_LAST) begin
               s_d     = sum_shifted;
               c_d     = fa_co;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      bus.busy = (state_q == ST_RUN);
      bus.done = done_q;
      bus.s    = s_q;
      bus.c    = c_q;
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed handshake cases plus back-to-back random additions vs a + b + cin.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      tick();
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
   endtask

   // Waits for done (bounded), checking busy and held outputs meanwhile, then latency and result.
   task automatic expect_result(input string tag, input logic [WIDTH:0] exp, input int elapsed);
      logic [WIDTH:0] old;
      int cyc;
      old = {bus.c, bus.s};
      cyc = elapsed;
      while (!bus.done && cyc < WIDTH + 4) begin
         check({tag, "_busy"}, 64'(bus.busy), 64'(1));
         check({tag, "_hold"}, 64'({bus.c, bus.s}), 64'(old));
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(WIDTH));
      check({tag, "_done"}, 64'(bus.done), 64'(1));
      check({tag, "_sum"}, 64'({bus.c, bus.s}), 64'(exp));
      check({tag, "_idle"}, 64'(bus.busy), 64'(0));
      tick();
      check({tag, "_pulse"}, 64'(bus.done), 64'(0));
   endtask

   initial begin
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic             cin_r;
      logic             exp_done;
      logic [WIDTH:0]   q[$];
      logic [WIDTH:0]   e;
      int               rem;
      int               extra;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      tick();
      tick();
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_sum",  64'({bus.c, bus.s}), 64'(0));
      rst = 1'b0;
      tick();

      launch(8'h35, 8'h4A, 1'b0);
      expect_result("t35_4a", 9'h07F, 0);
      launch(8'hFF, 8'h01, 1'b0);
      expect_result("tff_01", 9'h100, 0);
      launch(8'hFF, 8'hFF, 1'b1);
      expect_result("tff_ff_c", 9'h1FF, 0);

      // A start pulse mid-flight must be ignored.
      launch(8'h10, 8'h20, 1'b0);
      tick();
      tick();
      bus.start = 1'b1;
      bus.a     = 8'hAA;
      bus.b     = 8'h55;
      tick();
      bus.start = 1'b0;
      expect_result("midstart", 9'h030, 3);
      extra = 0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         if (bus.done) extra++;
         tick();
      end
      check("midstart_extra_done", 64'(extra), 64'(0));

      // Abort by reset in the middle of an addition.
      launch(8'h5A, 8'h33, 1'b1);
      tick();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(bus.busy), 64'(0));
      check("abort_done", 64'(bus.done), 64'(0));
      check("abort_sum",  64'({bus.c, bus.s}), 64'(0));
      tick();
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < WIDTH + 3; i++) begin
         if (bus.done || bus.busy) extra++;
         tick();
      end
      check("abort_no_done", 64'(extra), 64'(0));
      launch(8'h01, 8'h02, 1'b0);
      expect_result("post_rst", 9'h003, 0);

      // Continuous start with random operands: an addition is accepted every WIDTH+1 edges.
      rem = 0;
      bus.start = 1'b1;
      for (int i = 0; i < 20 * (WIDTH + 1); i++) begin
         a_r   = WIDTH'($urandom);
         b_r   = WIDTH'($urandom);
         cin_r = 1'($urandom);
         bus.a   = a_r;
         bus.b   = b_r;
         bus.cin = cin_r;
         tick();
         exp_done = 1'b0;
         if (rem == 0) begin
            e = (WIDTH+1)'(a_r) + (WIDTH+1)'(b_r) + (WIDTH+1)'(cin_r);
            q.push_back(e);
            rem = WIDTH;
         end else begin
            rem--;
            exp_done = (rem == 0);
         end
         check("rand_done", 64'(bus.done), 64'(exp_done));
         if (exp_done && q.size() > 0) begin
            e = q.pop_front();
            check("rand_sum", 64'({bus.c, bus.s}), 64'(e));
         end
      end
      bus.start = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that consumes two WIDTH-bit operands and a carry-in, and produces their sum one bit per clock. Each bit is computed by a full adder built from two half-adder instances. It is the first sequential consumer of the gate-level half adder in the datapath, and it trades area for latency. A start/busy/done handshake lets a controller or bench launch one addition at a time.

## Interface
- WIDTH, default 8: operand and sum width; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in; sampled on the accepting edge only.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; marks that s/c have just updated.
- s  out  WIDTH  registered sum; holds the last result.
- c  out  1  registered carry-out; holds the last result.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 on an edge (accept edge):
  - load a and b into right-shift registers.
  - load cin into the carry flop.
  - clear the bit counter (width $clog2(WIDTH)).
  - go to RUN.
- RUN, each edge:
  - sum_bit = a_sr[0] ^ b_sr[0] ^ carry.
  - carry <= (a_sr[0]&b_sr[0]) | (carry&(a_sr[0]^b_sr[0])), taken from the fa sub-module.
  - sum_bit is shifted into the MSB of the sum shift register; the operand registers shift right.
  - counter increments.
- RUN, on the edge where the counter equals WIDTH-1:
  - s <= the completed sum register; c <= the final carry.
  - done <= 1; go to IDLE.
- s and c change only on that completing edge. They hold their old values throughout RUN.
- Arithmetic: {c,s} = a + b + cin, exact, no saturation. Full-scale inputs wrap into c.
- start while busy=1: ignored, with no effect on the operation in flight.
- Operand changes after the accept edge: no effect.
- Reset values: busy=0, done=0, s=0, c=0, state IDLE. Internal shift registers, carry flop and counter are all 0.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and s/c go to 0.

## Timing
- Accept edge E0; busy rises after E0.
- Bits are computed on edges E1..E(WIDTH).
- On edge E(WIDTH): s/c update, done goes high and busy goes low.
- done is high for exactly one cycle, between E(WIDTH) and E(WIDTH+1).
- Latency: WIDTH cycles from the accept edge to the result.
- start high during the done cycle is accepted at E(WIDTH+1). Maximum throughput is one addition per WIDTH+1 cycles.
- Outputs are fully registered; there is no combinational path from any input to any output.

## Structure
- No shared package.
- State encoding (IDLE=0, RUN=1) and the counter width are localparams in serial_adder.
- Sub-module fa:
  - ports a, b, ci, s, co.
  - built from two ha instances plus an OR for co.
  - fa is purely combinational; the carry flop stays in serial_adder.
- Target 150–250 lines including fa.

## Test plan (WIDTH=8)
- a=8'h35, b=8'h4A, cin=0, one-cycle start -> busy for 8 cycles, then done pulse with s=8'h7F, c=0.
- a=8'hFF, b=8'h01, cin=0 -> s=8'h00, c=1.
- a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, c=1.
- Launch a=8'h10, b=8'h20. At cycle 3, pulse start with a=8'hAA, b=8'h55 -> result is s=8'h30, c=0, and exactly one done pulse.
- Launch an addition, assert rst at cycle 4 -> busy, done, s and c read 0 immediately and no done follows. A later start with a=8'h01, b=8'h02 gives s=8'h03.
- Hold start=1 continuously with random operands -> done pulses every 9 cycles, and every {c,s} matches a+b+cin sampled at the accept edge.
